// File: rtl/decoder_sel_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_sel_queue
//  Description : Request queue feeding a binary-to-one-hot decoder. Each
//                queued {index, dwell} selection is held on registered
//                enable/index outputs for dwell+1 cycles, with one
//                enable-low gap between back-to-back selections.
//  Revision    : 1.0  initial release
// ============================================================================
module decoder_sel_queue #(
  parameter int K       = 6,
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [K-1:0]             req_index,
  input  logic [DWELL_W-1:0]       req_dwell,
  input  logic                     flush,
  output logic                     sel_enable,
  output logic [K-1:0]             sel_index,
  output logic                     busy,
  output logic                     done_pulse,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = K + DWELL_W;

  localparam logic [LW-1:0]      c_level_full = LW'(DEPTH);
  localparam logic [LW-1:0]      c_level_one  = LW'(1);
  localparam logic [PW-1:0]      c_ptr_one    = PW'(1);
  localparam logic [DWELL_W-1:0] c_dwell_one  = DWELL_W'(1);

  // Reject unsupported depths at elaboration time.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("decoder_sel_queue: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DWELL_W-1:0]  r_count;
  logic [EW-1:0]       r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;

  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [EW-1:0]       w_head;

  assign w_empty = (level == '0);
  assign w_full  = (level == c_level_full);

  // Only the ready signal is allowed a combinational path from inputs.
  assign req_ready = !w_full && !flush;
  assign w_push    = req_valid && req_ready;

  // IDLE pops whenever something is queued; GAP always pops (the queue is
  // known non-empty there, the empty guard only keeps pointers coherent).
  assign w_pop = !flush && !w_empty &&
                 ((r_state == ST_IDLE) || (r_state == ST_GAP));

  assign w_head = r_mem[r_rd_ptr];

  // Busy looks only at registered state and occupancy.
  assign busy = (r_state != ST_IDLE) || !w_empty;

  // Request storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_index, req_dwell};
    end
  end

  // FIFO pointers and occupancy; flush empties the queue in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        level <= level + c_level_one;
      end else if (!w_push && w_pop) begin
        level <= level - c_level_one;
      end
    end
  end

  // Selection sequencer: IDLE -> HOLD (dwell+1 cycles) -> GAP/IDLE,
  // with enable, index and done pulse all driven from registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      sel_enable <= 1'b0;
      sel_index  <= '0;
      done_pulse <= 1'b0;
    end else if (flush) begin
      // Aborted hold: no completion pulse, index keeps its last value.
      r_state    <= ST_IDLE;
      r_count    <= '0;
      sel_enable <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            sel_index  <= w_head[EW-1:DWELL_W];
            r_count    <= w_head[DWELL_W-1:0];
            sel_enable <= 1'b1;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_count == '0) begin
            sel_enable <= 1'b0;
            done_pulse <= 1'b1;
            r_state    <= w_empty ? ST_IDLE : ST_GAP;
          end else begin
            r_count <= r_count - c_dwell_one;
          end
        end
        ST_GAP: begin
          if (w_pop) begin
            sel_index  <= w_head[EW-1:DWELL_W];
            r_count    <= w_head[DWELL_W-1:0];
            sel_enable <= 1'b1;
            r_state    <= ST_HOLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          sel_enable <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
